// File: rtl/gb_fetch_engine.sv
// Block-read sequencer for the global buffer: issues addresses, tracks the fixed read latency,
// and returns words on a valid/ready stream. Optional stall counter: define GB_FETCH_STALL_CNT_EN.
module gb_fetch_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            stride,
    input  logic [15:0]           length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef GB_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [ADDR_WIDTH-1:0]   r_addr_cnt;
    logic [7:0]              r_stride;
    logic [15:0]             r_remaining;

    // Tag for the address currently presented on raddr, then its journey through the buffer latency.
    logic                    r_issue_v;
    logic                    r_issue_last;
    logic [RD_LATENCY-1:0]   r_pipe_v;
    logic [RD_LATENCY-1:0]   r_pipe_last;

    logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_fifo_last;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_cnt;

    logic [CNT_W-1:0]        w_outstanding;
    logic                    w_credit;
    logic                    w_start_ok;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_nempty;
    logic                    w_head_last;
    logic                    w_finish;

    always_comb begin
        w_outstanding = CNT_W'(r_issue_v);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_outstanding = w_outstanding + CNT_W'(r_pipe_v[i]);
        end
    end

    // Every word in flight already owns a FIFO slot, so the buffer can never overrun the FIFO.
    assign w_credit      = ({1'b0, w_outstanding} + {1'b0, r_fifo_cnt}) < (CNT_W+1)'(FIFO_DEPTH);
    assign w_start_ok    = start && (r_state == ST_IDLE);
    assign w_push        = r_pipe_v[RD_LATENCY-1];
    assign w_fifo_nempty = (r_fifo_cnt != '0);
    assign w_pop         = w_fifo_nempty && m_ready;
    assign w_head_last   = r_fifo_last[r_rd_ptr];
    assign w_finish      = (r_state == ST_DRAIN) && w_pop && w_head_last && (w_outstanding == '0);

    // The first word issues on the accepting edge so raddr shows base_addr in the cycle after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_raddr      <= '0;
            r_addr_cnt   <= '0;
            r_stride     <= '0;
            r_remaining  <= '0;
            r_issue_v    <= 1'b0;
            r_issue_last <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_issue_v    <= 1'b0;
            r_issue_last <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        if (length == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_raddr      <= base_addr;
                            r_addr_cnt   <= base_addr + ADDR_WIDTH'(stride);
                            r_stride     <= stride;
                            r_remaining  <= length - 16'd1;
                            r_issue_v    <= 1'b1;
                            r_issue_last <= (length == 16'd1);
                            r_busy       <= 1'b1;
                            r_state      <= (length == 16'd1) ? ST_DRAIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_credit) begin
                        r_raddr      <= r_addr_cnt;
                        r_addr_cnt   <= r_addr_cnt + ADDR_WIDTH'(r_stride);
                        r_remaining  <= r_remaining - 16'd1;
                        r_issue_v    <= 1'b1;
                        r_issue_last <= (r_remaining == 16'd1);
                        if (r_remaining == 16'd1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_finish) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_v    <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_v[0]    <= r_issue_v;
            r_pipe_last[0] <= r_issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_last[r_wr_ptr] <= r_pipe_last[RD_LATENCY-1];
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            end
        end
    end

`ifdef GB_FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_RUN) && !w_credit && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Gated so an empty FIFO presents zeros rather than stale storage.
    assign busy    = r_busy;
    assign done    = r_done;
    assign raddr   = r_raddr;
    assign m_valid = w_fifo_nempty;
    assign m_data  = w_fifo_nempty ? r_fifo_data[r_rd_ptr] : '0;
    assign m_last  = w_fifo_nempty && w_head_last;

endmodule

// File: tb/tb_gb_fetch_engine.sv
// Self-checking bench for gb_fetch_engine: buffer model with 3-cycle read latency and an
// address-derived reference for the returned stream.
module tb_gb_fetch_engine;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  base_addr;
    logic [7:0]   stride;
    logic [15:0]  length;
    logic         busy;
    logic         done;
    logic [15:0]  raddr;
    logic [127:0] rd_data;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;
`ifdef GB_FETCH_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [127:0] rx_data[$];
    logic         rx_last[$];
    logic [127:0] buf_d1;
    logic [127:0] buf_d2;

    gb_fetch_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef GB_FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer contents as a pure function of the word address.
    function automatic logic [127:0] data_of(input logic [15:0] a);
        logic [31:0] sq;
        sq = {16'h0, a} * {16'h0, a};
        return {a ^ 16'hA5A5, a, 16'hBEEF, ~a, sq, a + 16'd1, a ^ 16'h3C3C};
    endfunction

    // Global buffer read port: address sampled on the edge, data valid three cycles later.
    always @(posedge clk) begin
        buf_d1  <= data_of(raddr);
        buf_d2  <= buf_d1;
        rd_data <= buf_d2;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    128'(busy),    128'(0));
        check({tag, "_done"},    128'(done),    128'(0));
        check({tag, "_raddr"},   128'(raddr),   128'(0));
        check({tag, "_m_valid"}, 128'(m_valid), 128'(0));
        check({tag, "_m_last"},  128'(m_last),  128'(0));
        check({tag, "_m_data"},  m_data,        128'(0));
    endtask

    // mode 0: m_ready high; mode 1: low for 30 cycles then high; mode 2: random.
    task automatic run_cmd(input logic [15:0] b, input logic [7:0] s, input logic [15:0] n,
                           input int mode, input bit chk_raddr, input bit restart);
        bit seen;
        int i;
        logic [15:0] exp_a;
        rx_data.delete();
        rx_last.delete();
        done_cnt = 0;
        seen = 0;
        tick();
        start = 1'b1; base_addr = b; stride = s; length = n;
        m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            tick();
            base_addr = 16'($urandom);
            stride    = 8'($urandom);
            length    = 16'($urandom);
            if (restart && cyc == 2) begin
                start = 1'b1; base_addr = 16'h8000; length = 16'd5;
            end else begin
                start = 1'b0;
            end
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc > 30) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (chk_raddr && cyc <= int'(n)) begin
                exp_a = 16'(b + (cyc - 1) * s);
                check($sformatf("raddr_c%0d", cyc), 128'(raddr), 128'(exp_a));
            end
            if (chk_raddr && cyc == 4) check("mvalid_before_latency", 128'(m_valid), 128'(0));
            if (chk_raddr && cyc == 5) begin
                check("mvalid_first", 128'(m_valid), 128'(1));
                check("mdata_first", m_data, data_of(b));
            end
            if (mode == 1 && cyc == 25) begin
                exp_a = 16'(b + 7 * s);
                check("raddr_credit_stop", 128'(raddr), 128'(exp_a));
                check("mvalid_stalled", 128'(m_valid), 128'(1));
            end
            if (done) begin
                seen = 1;
                check("busy_at_done", 128'(busy), 128'(0));
                break;
            end
        end
        check("done_seen", 128'(seen), 128'(1));
        tick();
        m_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        check("done_count", 128'(done_cnt), 128'(1));
        check("rx_count", 128'(rx_data.size()), 128'(n));
        i = 0;
        while (i < int'(n) && i < rx_data.size()) begin
            exp_a = 16'(b + i * s);
            check($sformatf("word%0d_data", i), rx_data[i], data_of(exp_a));
            check($sformatf("word%0d_last", i), 128'(rx_last[i]), 128'(i == int'(n) - 1));
            i++;
        end
        $display("cmd base=%04h stride=%0d len=%0d mode=%0d words=%0d", b, s, n, mode, rx_data.size());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; length = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
`ifdef GB_FETCH_STALL_CNT_EN
        check("reset_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
        tick();
        rst_n = 1'b1;

        run_cmd(16'h0010, 8'd1, 16'd4, 0, 1'b1, 1'b0);
        run_cmd(16'hFFFE, 8'd2, 16'd3, 0, 1'b1, 1'b0);
        run_cmd(16'h0100, 8'd1, 16'd20, 1, 1'b0, 1'b0);
`ifdef GB_FETCH_STALL_CNT_EN
        check("stall_cnt_nonzero", 128'(stall_cnt != 32'd0), 128'(1));
`endif

        // Zero-length command: done only, nothing emitted.
        done_cnt = 0;
        rx_data.delete();
        rx_last.delete();
        tick();
        start = 1'b1; base_addr = 16'h1234; stride = 8'd1; length = 16'd0; m_ready = 1'b1;
        @(negedge clk);
        check("zl_done_not_same_cycle", 128'(done), 128'(0));
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zl_done", 128'(done), 128'(1));
        check("zl_busy", 128'(busy), 128'(0));
        check("zl_mvalid", 128'(m_valid), 128'(0));
        tick();
        @(negedge clk);
        check("zl_done_drop", 128'(done), 128'(0));
        check("zl_busy_after", 128'(busy), 128'(0));
        check("zl_no_words", 128'(rx_data.size()), 128'(0));
        $display("cmd zero-length done_count=%0d", done_cnt);
`ifdef GB_FETCH_STALL_CNT_EN
        check("stall_cnt_cleared", 128'(stall_cnt), 128'(0));
`endif

        run_cmd(16'h0200, 8'd1, 16'd6, 0, 1'b1, 1'b1);

        // Reset while three words are still in the buffer pipeline.
        rx_data.delete();
        rx_last.delete();
        done_cnt = 0;
        tick();
        start = 1'b1; base_addr = 16'h2000; stride = 8'd1; length = 16'd10; m_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("pre_reset_busy", 128'(busy), 128'(1));
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        #1 rst_n = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("post_reset_no_words", 128'(rx_data.size()), 128'(0));
        check("post_reset_no_done", 128'(done_cnt), 128'(0));
        check("post_reset_mvalid", 128'(m_valid), 128'(0));
        $display("cmd reset-mid-command words=%0d", rx_data.size());
        run_cmd(16'h4000, 8'd1, 16'd2, 0, 1'b1, 1'b0);

        run_cmd(16'($urandom), 8'd3, 16'd100, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gb_fetch_engine.md
# gb_fetch_engine

Read-side sequencer for the global buffer. It takes a block-read command (base, stride, length), drives the buffer's read-address port one word per cycle, and tracks the buffer's fixed 3-cycle read latency with a valid pipeline. Returned words land in a small FIFO and leave on a valid/ready stream. Issue is credit-limited, so the buffer, which has no backpressure, never overruns the FIFO. It sits between the global buffer's read port (raddr_a/dout_a or raddr_b/dout_b) and the PE-array input stream.

## Interface
- addr_width, 16, buffer word-address width; bit 15 selects output region, bit 14 selects weight region
- data_width, 128, buffer word width
- RD_LATENCY, 3, cycles from raddr sampled to matching rd_data valid
- FIFO_DEPTH, 8, return FIFO entries; power of two, at least RD_LATENCY+1

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; accepted only in IDLE
- base_addr  in  addr_width  first word address; sampled on accepted start
- stride  in  8  unsigned address increment per word; sampled on start
- length  in  16  word count; sampled on start; 0 is legal
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse when a command completes
- raddr  out  addr_width  read address to the buffer
- rd_data  in  data_width  buffer read data (dout_a or dout_b)
- m_valid  out  1  stream word valid
- m_ready  in  1  stream consumer ready
- m_data  out  data_width  stream word (FIFO head)
- m_last  out  1  high with the final word of a command

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN on start with length != 0. Base, stride and length are latched. The address counter is set to base_addr and the remaining count to length.
- IDLE with start and length == 0: done pulses the next cycle, the FSM stays IDLE, and no words are emitted.
- start while busy is ignored and has no side effects.
- RUN: each cycle in which credit exists, raddr is set to the address counter and issue=1. The address counter increments by stride, wrapping modulo 2^addr_width. The remaining count decrements. When the last word issues, the FSM goes to DRAIN.
- Credit rule: issue is allowed only when outstanding + fifo_count < FIFO_DEPTH. outstanding is the number of valid bits set in the latency pipe.
- Latency pipe: an RD_LATENCY-deep shift register carries {valid, last}. Its tail pushes rd_data into the FIFO.
- A FIFO push and pop in the same cycle leaves the count unchanged. Overflow cannot occur under the credit rule.
- m_valid = FIFO not empty. A pop happens when m_valid && m_ready. m_last is stored per entry.
- DRAIN → IDLE when the pipe is empty and the last-tagged word pops. done pulses in that same transition cycle.
- When not issuing, raddr holds its last value. The buffer reads it harmlessly because the valid bit is 0.

## Timing
- Reset values: busy=0, done=0, raddr=0, m_valid=0, m_last=0, m_data=0. The FSM goes to IDLE, the pipe valids clear and the FIFO empties.
- Reset mid-command: data still in flight from the buffer is discarded and no done is produced.
- raddr is registered. The first issue is raddr=base_addr in the cycle after start.
- The word issued in cycle N appears on rd_data in cycle N+RD_LATENCY and is pushed at the end of that cycle. m_valid rises in cycle N+RD_LATENCY+1.
- With m_ready held high, throughput is 1 word/cycle. First-word latency from start is 1+RD_LATENCY+1 = 5 cycles.
- m_data and m_last stay stable while m_valid=1 && m_ready=0.
- done is registered, lasts exactly 1 cycle, and busy falls in the same cycle.

## Configuration
- GB_FETCH_STALL_CNT_EN defined: adds output stall_cnt [31:0].
  - It counts cycles in RUN where issue is blocked by credit.
  - It clears on an accepted start and saturates at 0xFFFFFFFF.
  - Its reset value is 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Base 0x0010, stride 1, length 4, m_ready=1 → raddr 0x0010..0x0013 on consecutive cycles; m_data equals buffer contents; m_last on the 4th word; done pulses once; busy is low afterwards.
- Base 0xFFFE, stride 2, length 3 → raddr 0xFFFE, 0x0000, 0x0002 (wrap); 3 words; m_last on the 3rd.
- Length 20, m_ready=0 for 30 cycles then 1 → issue stops after 8 outstanding+buffered; no word lost or duplicated; all 20 words arrive in order. With GB_FETCH_STALL_CNT_EN, stall_cnt is nonzero.
- Length 0 start → done pulses 1 cycle later; m_valid stays 0; busy never asserts. A second start during a 6-word command is ignored: exactly 6 words are emitted.
- rst_n pulsed low mid-command with 3 words in flight → all outputs go to reset values asynchronously. A new start, base 0x4000, length 2, returns only the 2 new words.
- Randomized m_ready toggling over a length-100 stride-3 read → output sequence matches the address-derived reference model; m_last on word 100 only.
